data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and block-granular data memory. It services byte reads and writes from its own 32-byte array, and stalls the CPU through BUSYWAIT only on a miss. It holds 8 lines of 4 bytes. Each line carries a 3-bit tag, a valid bit and a dirty bit.

---
 rtl/data_cache.sv | 157 +++++++++++++++
 tb/tb_data_cache.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines x 4 bytes, 3-bit tags.
// Hits complete with no stall; misses write back a dirty victim, then fetch the block.
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    localparam int unsigned LINES     = 8;
    localparam int unsigned LINE_BITS = 32;
    localparam int unsigned TAG_W     = 3;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned OFF_W     = 2;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MADDR_W   = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [LINE_BITS-1:0]   data_q [LINES];
    logic [LINE_BITS-1:0]   data_d [LINES];
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [TAG_W-1:0]       tag_d  [LINES];
    logic [LINES-1:0]       valid_q, valid_d;
    logic [LINES-1:0]       dirty_q, dirty_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [MADDR_W-1:0]     mem_address_q, mem_address_d;
    logic [LINE_BITS-1:0]   mem_writedata_q, mem_writedata_d;

    logic [TAG_W-1:0]       addr_tag;
    logic [IDX_W-1:0]       addr_idx;
    logic [OFF_W-1:0]       addr_off;
    logic [4:0]             byte_lsb;
    logic                   req;
    logic                   hit;
    logic                   idle_hit;

    assign addr_tag = ADDRESS[7:5];
    assign addr_idx = ADDRESS[4:2];
    assign addr_off = ADDRESS[1:0];
    assign byte_lsb = {addr_off, 3'b000};
    assign req      = READ | WRITE;
    assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign idle_hit = (state_q == IDLE) && hit;

    // CPU-facing outputs are combinational so hits never stall; simultaneous READ/WRITE acts as WRITE.
    assign BUSYWAIT = req && !idle_hit;
    assign READDATA = (idle_hit && READ && !WRITE) ? data_q[addr_idx][byte_lsb +: BYTE_W]
                                                   : BYTE_W'(0);

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

    // Next-state, array update and next memory-request values.
    always_comb begin
        state_d         = state_q;
        data_d          = data_q;
        tag_d           = tag_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_address_d   = MADDR_W'(0);
        mem_writedata_d = LINE_BITS'(0);

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (WRITE) begin
                            data_d[addr_idx][byte_lsb +: BYTE_W] = WRITEDATA;
                            dirty_d[addr_idx]                    = 1'b1;
                        end
                    end else if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!mem_busywait) begin
                    data_d[addr_idx]  = mem_readdata;
                    tag_d[addr_idx]   = addr_tag;
                    valid_d[addr_idx] = 1'b1;
                    dirty_d[addr_idx] = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Memory request outputs follow the state being entered, so they register with it.
        case (state_d)
            WRITEBACK: begin
                mem_write_d     = 1'b1;
                mem_address_d   = {tag_q[addr_idx], addr_idx};
                mem_writedata_d = data_q[addr_idx];
            end
            FETCH: begin
                mem_read_d    = 1'b1;
                mem_address_d = {addr_tag, addr_idx};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q         <= IDLE;
            valid_q         <= LINES'(0);
            dirty_q         <= LINES'(0);
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= MADDR_W'(0);
            mem_writedata_q <= LINE_BITS'(0);
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    // Line data and tags are qualified by valid, so they need no reset.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: miss/hit/write-back/allocate/reset scenarios
// against a small latency-programmable block memory.
module tb_data_cache;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int busy_cnt = 0;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory is busy for 'lat' cycles of each request, then completes.
    assign mem_busywait = (mem_read | mem_write) && (busy_cnt < lat);
    always @(posedge CLK) begin
        if (!(mem_read | mem_write) || !mem_busywait) busy_cnt <= 0;
        else                                          busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && BUSYWAIT; i++) begin
            @(negedge CLK);
            #1;
        end
        check(tag, BUSYWAIT, 0);
    endtask

    initial begin
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
        ADDRESS = 8'h00; WRITEDATA = 8'h00; mem_readdata = 32'h0;
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_writedata", mem_writedata, 0);
        check("rst_busywait", BUSYWAIT, 0);
        check("rst_readdata", READDATA, 8'h00);
        neg(1);
        RESET = 1'b0;

        // Cold read miss at 0x05
        neg(1);
        lat = 5; mem_readdata = 32'hDDCCBBAA;
        READ = 1'b1; ADDRESS = 8'h05;
        #1;
        check("cold_busy_req", BUSYWAIT, 1);
        check("cold_no_read_idle", mem_read, 0);
        check("cold_readdata_miss", READDATA, 8'h00);
        neg(1); #1;
        check("cold_fetch_read", mem_read, 1);
        check("cold_fetch_write", mem_write, 0);
        check("cold_fetch_addr", mem_address, 6'h01);
        check("cold_fetch_busy", BUSYWAIT, 1);
        check("cold_mem_busy", mem_busywait, 1);
        neg(5); #1;
        check("cold_last_fetch_read", mem_read, 1);
        check("cold_last_mem_busy", mem_busywait, 0);
        neg(1); #1;
        check("cold_hit_data", READDATA, 8'hBB);
        check("cold_hit_busy", BUSYWAIT, 0);
        check("cold_idle_read", mem_read, 0);

        // Read hit at 0x06
        neg(1);
        ADDRESS = 8'h06;
        #1;
        check("rdhit_data", READDATA, 8'hCC);
        check("rdhit_busy", BUSYWAIT, 0);
        neg(1); #1;
        check("rdhit_no_mem_read", mem_read, 0);

        // Write hit 0x04 <= 0x11
        READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h04; WRITEDATA = 8'h11;
        #1;
        check("wrhit_busy", BUSYWAIT, 0);
        check("wrhit_readdata", READDATA, 8'h00);
        neg(1);
        WRITE = 1'b0; READ = 1'b1;
        #1;
        check("wrhit_readback", READDATA, 8'h11);
        check("wrhit_no_mem_write", mem_write, 0);
        check("wrhit_no_mem_read", mem_read, 0);

        // Dirty conflict miss at 0x24
        neg(1);
        lat = 2; mem_readdata = 32'h44332211;
        ADDRESS = 8'h24;
        #1;
        check("dirty_busy_req", BUSYWAIT, 1);
        neg(1); #1;
        check("wb_write", mem_write, 1);
        check("wb_read", mem_read, 0);
        check("wb_addr", mem_address, 6'h01);
        check("wb_data", mem_writedata, 32'hDDCCBB11);
        neg(3); #1;
        check("dfetch_read", mem_read, 1);
        check("dfetch_write", mem_write, 0);
        check("dfetch_addr", mem_address, 6'h09);
        neg(3); #1;
        check("dirty_hit_data", READDATA, 8'h11);
        check("dirty_hit_busy", BUSYWAIT, 0);

        // Write miss allocate at 0x0A <= 0x7E
        neg(1);
        lat = 1; mem_readdata = 32'h0D0C0B0A;
        READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h0A; WRITEDATA = 8'h7E;
        #1;
        check("wmiss_busy_req", BUSYWAIT, 1);
        neg(1); #1;
        check("wmiss_fetch_read", mem_read, 1);
        check("wmiss_no_wb", mem_write, 0);
        check("wmiss_fetch_addr", mem_address, 6'h02);
        neg(2); #1;
        check("wmiss_busy_drop", BUSYWAIT, 0);
        neg(1);
        WRITE = 1'b0; READ = 1'b1;
        #1;
        check("wmiss_byte2", READDATA, 8'h7E);
        neg(1);
        ADDRESS = 8'h0B;
        #1;
        check("wmiss_byte3", READDATA, 8'h0D);

        // Conflict on index 2 proves the allocated line is dirty; then reset during FETCH
        neg(1);
        ADDRESS = 8'h2A; mem_readdata = 32'h55555555;
        neg(1); #1;
        check("wb2_write", mem_write, 1);
        check("wb2_addr", mem_address, 6'h02);
        check("wb2_data", mem_writedata, 32'h0D7E0B0A);
        neg(2); #1;
        check("fetch2_read", mem_read, 1);
        check("fetch2_addr", mem_address, 6'h0A);
        #1;
        RESET = 1'b1; READ = 1'b0;
        #1;
        check("rstf_mem_read", mem_read, 0);
        check("rstf_mem_write", mem_write, 0);
        check("rstf_busy", BUSYWAIT, 0);
        neg(1);
        RESET = 1'b0;

        // Line 2 was valid and dirty before reset: must now miss without write-back
        neg(1);
        mem_readdata = 32'h0D0C0B0A;
        READ = 1'b1; ADDRESS = 8'h0A;
        #1;
        check("post_rst_busy", BUSYWAIT, 1);
        neg(1); #1;
        check("post_rst_fetch", mem_read, 1);
        check("post_rst_no_wb", mem_write, 0);
        check("post_rst_addr", mem_address, 6'h02);
        wait_idle("post_rst_idle");
        check("post_rst_data", READDATA, 8'h0C);

        // READ 0x05 misses again after reset
        neg(1);
        ADDRESS = 8'h05;
        #1;
        check("re05_busy", BUSYWAIT, 1);
        neg(1); #1;
        check("re05_fetch", mem_read, 1);
        check("re05_addr", mem_address, 6'h01);
        wait_idle("re05_idle");
        check("re05_data", READDATA, 8'h0B);

        neg(1);
        READ = 1'b0;
        #1;
        check("end_busy", BUSYWAIT, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
